// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the register-file address decoder.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam int unsigned DECODE_ADDR_W = 64;
  localparam int unsigned INDEX_W       = 32;

  typedef struct packed {
    logic               in_range;
    logic [INDEX_W-1:0] index;
  } reg_decode_t;

  // Any set bit above the index field pushes the word number past num_regs,
  // so one magnitude compare covers both the index and the upper-bits check.
  function automatic reg_decode_t decode_reg_addr(
    input logic [DECODE_ADDR_W-1:0] addr,
    input int unsigned              data_width,
    input int unsigned              num_regs
  );
    reg_decode_t              res;
    logic [DECODE_ADDR_W-1:0] word;
    word         = (data_width == 32'd64) ? (addr >> 3'd3) : (addr >> 3'd2);
    res.in_range = (word < DECODE_ADDR_W'(num_regs));
    res.index    = word[INDEX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_channel #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;

  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: independent AW/W holding stages, byte-strobed
// commits with per-register write pulses, DECERR for out-of-range accesses.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_channel.slave        slave,
  output logic [DATA_WIDTH-1:0] reg_q [NUM_REGS],
  output logic [NUM_REGS-1:0]   wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  if (NUM_REGS < 32'd1) begin : g_bad_num_regs
    $error("axi_lite_regfile: NUM_REGS must be at least 1");
  end
  if ((DATA_WIDTH != 32'd32) && (DATA_WIDTH != 32'd64)) begin : g_bad_data_width
    $error("axi_lite_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (ADDR_WIDTH > DECODE_ADDR_W) begin : g_bad_addr_width
    $error("axi_lite_regfile: ADDR_WIDTH exceeds decoder width");
  end

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
  logic                  b_valid_q, b_valid_d;
  axi_resp_e             b_resp_q,  b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
  axi_resp_e             r_resp_q,  r_resp_d;
  logic [DATA_WIDTH-1:0] reg_d      [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic        aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  reg_decode_t w_dec_s, ar_dec_s;

  // Readies depend only on local state, never on the incoming valids.
  assign slave.aw_ready = !rst && !aw_held_q;
  assign slave.w_ready  = !rst && !w_held_q;
  assign slave.ar_ready = !rst && !r_valid_q;
  assign slave.b_valid  = b_valid_q;
  assign slave.b_resp   = b_resp_q;
  assign slave.r_valid  = r_valid_q;
  assign slave.r_data   = r_data_q;
  assign slave.r_resp   = r_resp_q;
  assign wr_pulse       = wr_pulse_q;

  assign aw_hs_s  = slave.aw_valid && slave.aw_ready;
  assign w_hs_s   = slave.w_valid  && slave.w_ready;
  assign ar_hs_s  = slave.ar_valid && slave.ar_ready;
  assign commit_s = aw_held_q && w_held_q && !b_valid_q;
  assign w_dec_s  = decode_reg_addr(DECODE_ADDR_W'(aw_addr_q), DATA_WIDTH, NUM_REGS);
  assign ar_dec_s = decode_reg_addr(DECODE_ADDR_W'(slave.ar_addr), DATA_WIDTH, NUM_REGS);

  // Holding stages: capture AW and W independently, release both on commit.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (commit_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        aw_addr_d = slave.aw_addr;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        w_data_d = slave.w_data;
        w_strb_d = slave.w_strb;
      end else begin
        w_held_d = w_held_q;
      end
    end
  end

  // Commit: strobed register update, write pulse and B response.
  always_comb begin
    reg_d      = reg_q;
    wr_pulse_d = '0;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    if (commit_s) begin
      b_valid_d = 1'b1;
      if (w_dec_s.in_range) begin
        b_resp_d = OKAY;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (w_dec_s.index == INDEX_W'(r)) begin
            wr_pulse_d[r] = 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (w_strb_q[b]) begin
                reg_d[r][8*b +: 8] = w_data_q[8*b +: 8];
              end else begin
                reg_d[r][8*b +: 8] = reg_q[r][8*b +: 8];
              end
            end
          end else begin
            wr_pulse_d[r] = 1'b0;
          end
        end
      end else begin
        b_resp_d = DECERR;
      end
    end else if (b_valid_q && slave.b_ready) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // Read path samples the pre-commit register contents.
  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    if (ar_hs_s) begin
      r_valid_d = 1'b1;
      r_data_d  = '0;
      if (ar_dec_s.in_range) begin
        r_resp_d = OKAY;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          if (ar_dec_s.index == INDEX_W'(r)) begin
            r_data_d = reg_q[r];
          end else begin
            r_data_d = r_data_d;
          end
        end
      end else begin
        r_resp_d = DECERR;
      end
    end else if (r_valid_q && slave.r_ready) begin
      r_valid_d = 1'b0;
    end else begin
      r_valid_d = r_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      reg_q      <= '{default: '0};
      wr_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      reg_q      <= reg_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with hand-computed expectations.
module tb_axi_lite_regfile;

  logic        clk;
  logic        rst;
  logic [63:0] reg_q [16];
  logic [15:0] wr_pulse;
  int          checks;
  int          failures;

  axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) bus ();

  axi_lite_regfile #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .NUM_REGS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .slave    (bus.slave),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_aw(input logic [47:0] addr);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
  endtask

  task automatic put_w(input logic [63:0] data, input logic [7:0] strb);
    bus.w_valid = 1'b1;
    bus.w_data  = data;
    bus.w_strb  = strb;
  endtask

  task automatic put_ar(input logic [47:0] addr);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
  endtask

  task automatic clear_valids();
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.ar_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.aw_prot  = 3'd0;
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.w_strb   = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.ar_prot  = 3'd0;
    bus.r_ready  = 1'b0;
    step();
    step();
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_w_ready",  64'(bus.w_ready),  64'd0);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_b_valid",  64'(bus.b_valid),  64'd0);
    chk("rst_r_valid",  64'(bus.r_valid),  64'd0);
    rst = 1'b0;
    step();
    chk("idle_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("idle_reg1",     reg_q[1],          64'd0);
    chk("idle_pulse",    64'(wr_pulse),     64'd0);

    // Full-strobe write, AW and W together
    bus.b_ready = 1'b1;
    bus.r_ready = 1'b1;
    put_aw(48'h8);
    put_w(64'h1122334455667788, 8'hFF);
    step();
    clear_valids();
    chk("t1_held_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("t1_no_b_yet",      64'(bus.b_valid),  64'd0);
    step();
    chk("t1_b_valid", 64'(bus.b_valid), 64'd1);
    chk("t1_b_resp",  64'(bus.b_resp),  64'd0);
    chk("t1_reg1",    reg_q[1],         64'h1122334455667788);
    chk("t1_pulse",   64'(wr_pulse),    64'h2);
    step();
    chk("t1_b_done",     64'(bus.b_valid), 64'd0);
    chk("t1_pulse_done", 64'(wr_pulse),    64'd0);

    // W ahead of AW, partial strobe
    put_w(64'hFFFFFFFFFFFFFFFF, 8'h0F);
    step();
    clear_valids();
    chk("t2_w_held", 64'(bus.w_ready), 64'd0);
    step();
    step();
    chk("t2_no_commit", 64'(bus.b_valid), 64'd0);
    put_aw(48'h8);
    step();
    clear_valids();
    chk("t2_b_pending", 64'(bus.b_valid), 64'd0);
    step();
    chk("t2_b_valid", 64'(bus.b_valid), 64'd1);
    chk("t2_reg1",    reg_q[1],         64'h11223344FFFFFFFF);
    chk("t2_pulse",   64'(wr_pulse),    64'h2);
    step();

    // In-range and out-of-range reads, out-of-range write
    put_ar(48'h8);
    step();
    clear_valids();
    chk("t3_r_valid",  64'(bus.r_valid),  64'd1);
    chk("t3_r_data",   bus.r_data,        64'h11223344FFFFFFFF);
    chk("t3_r_resp",   64'(bus.r_resp),   64'd0);
    chk("t3_ar_ready", 64'(bus.ar_ready), 64'd0);
    step();
    chk("t3_r_done", 64'(bus.r_valid), 64'd0);
    put_ar(48'h80);
    step();
    clear_valids();
    chk("t3_oor_r_valid", 64'(bus.r_valid), 64'd1);
    chk("t3_oor_r_data",  bus.r_data,       64'd0);
    chk("t3_oor_r_resp",  64'(bus.r_resp),  64'd3);
    step();
    put_aw(48'h80);
    put_w(64'hDEADBEEF, 8'hFF);
    step();
    clear_valids();
    step();
    chk("t3_oor_b_valid", 64'(bus.b_valid), 64'd1);
    chk("t3_oor_b_resp",  64'(bus.b_resp),  64'd3);
    chk("t3_oor_pulse",   64'(wr_pulse),    64'd0);
    chk("t3_oor_reg0",    reg_q[0],         64'd0);
    step();

    // Back-pressure on B stalls the second commit
    bus.b_ready = 1'b0;
    put_aw(48'h10);
    put_w(64'h55, 8'hFF);
    step();
    clear_valids();
    step();
    chk("t4_b1_valid", 64'(bus.b_valid), 64'd1);
    chk("t4_reg2",     reg_q[2],         64'h55);
    put_aw(48'h18);
    put_w(64'h66, 8'hFF);
    step();
    clear_valids();
    chk("t4_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("t4_w_ready",  64'(bus.w_ready),  64'd0);
    step();
    step();
    chk("t4_b_stuck",   64'(bus.b_valid), 64'd1);
    chk("t4_reg3_wait", reg_q[3],         64'd0);
    chk("t4_no_pulse",  64'(wr_pulse),    64'd0);
    bus.b_ready = 1'b1;
    step();
    chk("t4_b1_done",   64'(bus.b_valid), 64'd0);
    chk("t4_reg3_still", reg_q[3],        64'd0);
    step();
    chk("t4_b2_valid", 64'(bus.b_valid), 64'd1);
    chk("t4_b2_resp",  64'(bus.b_resp),  64'd0);
    chk("t4_reg3",     reg_q[3],         64'h66);
    chk("t4_pulse3",   64'(wr_pulse),    64'h8);
    step();

    // Read racing a commit to the same register
    put_aw(48'h10);
    put_w(64'hAA, 8'hFF);
    step();
    clear_valids();
    put_ar(48'h10);
    step();
    clear_valids();
    chk("t5_r_valid", 64'(bus.r_valid), 64'd1);
    chk("t5_r_old",   bus.r_data,       64'h55);
    chk("t5_reg2",    reg_q[2],         64'hAA);
    chk("t5_b_valid", 64'(bus.b_valid), 64'd1);
    step();
    put_ar(48'h10);
    step();
    clear_valids();
    chk("t5_r_new", bus.r_data, 64'hAA);
    step();

    // Reset while AW is held and a read response is pending
    bus.r_ready = 1'b0;
    put_aw(48'h8);
    put_ar(48'h8);
    step();
    clear_valids();
    chk("t6_r_pending", 64'(bus.r_valid),  64'd1);
    chk("t6_aw_held",   64'(bus.aw_ready), 64'd0);
    rst = 1'b1;
    step();
    chk("t6_rst_r_valid",  64'(bus.r_valid),  64'd0);
    chk("t6_rst_b_valid",  64'(bus.b_valid),  64'd0);
    chk("t6_rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("t6_reg1",     reg_q[1],          64'd0);
    chk("t6_reg2",     reg_q[2],          64'd0);
    chk("t6_r_data",   bus.r_data,        64'd0);
    chk("t6_r_resp",   64'(bus.r_resp),   64'd0);
    chk("t6_b_resp",   64'(bus.b_resp),   64'd0);
    chk("t6_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("t6_w_ready",  64'(bus.w_ready),  64'd1);
    chk("t6_pulse",    64'(wr_pulse),     64'd0);
    put_w(64'h1234, 8'hFF);
    step();
    clear_valids();
    step();
    step();
    chk("t6_no_stale_commit", 64'(bus.b_valid), 64'd0);
    chk("t6_reg1_after",      reg_q[1],         64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
